// File: rtl/uart_echo_responder.sv
// UART echo responder: buffers received bytes in a FIFO and replays each one through the UART TX core.
// Optional build macro UART_ECHO_INCR_EN: echoed byte = received byte + INCR (mod 256).
module uart_echo_responder #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [7:0]  INCR        = 8'd1,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [3:0]  svn_seg_0,
  output logic [9:0]  states_leds,
  output logic [15:0] echo_count,
  output logic        overflow
);

  // state     | meaning
  // IDLE      | waiting for a buffered byte and an idle transmitter
  // WAIT_ACK  | tx_start issued, waiting for tx_busy to rise (or timeout)
  // WAIT_DONE | transmitter busy, waiting for it to finish
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  TMO_LAST = 8'(ACK_TIMEOUT - 1);

`ifdef UART_ECHO_INCR_EN
  localparam bit INCR_EN = 1'b1;
`else
  localparam bit INCR_EN = 1'b0;
`endif
  localparam logic [7:0] ECHO_ADD = INCR_EN ? INCR : 8'd0;

  logic [1:0]    state;
  logic [7:0]    tmo_cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign pop   = (state == S_IDLE) && !empty && !tx_busy;
  // A pop in the same cycle frees an entry, so a full FIFO still accepts the byte
  assign push  = rx_ready && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      svn_seg_0 <= 4'h0;
    end else begin
      if (rx_ready) svn_seg_0 <= rx_data[3:0];
      if (rx_ready && !push) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tmo_cnt    <= 8'd0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      echo_count <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          tx_start <= 1'b0;
          tmo_cnt  <= 8'd0;
          if (pop) begin
            tx_data    <= mem[rd_ptr] + ECHO_ADD;
            tx_start   <= 1'b1;
            echo_count <= echo_count + 16'd1;
            state      <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          tx_start <= 1'b0;
          if (tx_busy) begin
            tmo_cnt <= 8'd0;
            state   <= S_WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            // No acknowledge from TX: treat the byte as sent
            tmo_cnt <= 8'd0;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          tx_start <= 1'b0;
          if (!tx_busy) state <= S_IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          tmo_cnt  <= 8'd0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Status is live; gated by rst so every output reads 0 during reset
  assign states_leds = rst ? 10'd0 :
                       {3'b000, tx_busy, overflow, full, empty,
                        state == S_WAIT_DONE, state == S_WAIT_ACK, state == S_IDLE};

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for uart_echo_responder; expected echo bytes are queued at stimulus time
// and a negedge monitor pops and compares them on every tx_start.
module tb_uart_echo_responder;

`ifdef UART_ECHO_INCR_EN
  localparam logic [7:0] INC = 8'd1;
`else
  localparam logic [7:0] INC = 8'd0;
`endif

  logic        clk;
  logic        rst;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [3:0]  svn_seg_0;
  logic [9:0]  states_leds;
  logic [15:0] echo_count;
  logic        overflow;

  uart_echo_responder #(.FIFO_DEPTH(8), .INCR(8'd1), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .svn_seg_0(svn_seg_0),
    .states_leds(states_leds), .echo_count(echo_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // TX model: busy rises one cycle after tx_start and stays high for 10 cycles
  bit ack_en = 1'b1;
  bit hold_busy = 1'b0;
  bit model_busy = 1'b0;
  bit ack_pend = 1'b0;
  int busy_left = 0;
  assign tx_busy = hold_busy | model_busy;

  always @(negedge clk) begin
    if (rst) begin
      ack_pend  = 1'b0;
      busy_left = 0;
    end else begin
      if (ack_pend) begin
        ack_pend  = 1'b0;
        busy_left = 10;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (tx_start && ack_en) ack_pend = 1'b1;
    end
    model_busy = (busy_left > 0);
  end

  // Monitor
  bit prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst && tx_start) begin
      n_start++;
      check("tx_start_width", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_tx_start: got data %0h, required no transmit", tx_data);
      end else begin
        check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_start = !rst && tx_start;
  end

  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!(states_leds[0] && states_leds[3] && !tx_busy && !ack_pend && exp_q.size() == 0)
           && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, k < 2000}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    rst = 1'b1;
    rx_ready = 1'b0;
    rx_data = 8'h00;
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_svn", {28'd0, svn_seg_0}, 32'd0);
    check("rst_leds", {22'd0, states_leds}, 32'd0);
    check("rst_echo_count", {16'd0, echo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold_busy = 1'b0;
    #1;
    check("idle_leds", {22'd0, states_leds}, 32'h009);

    // Single echo and latency
    exp_q.push_back(8'h41 + INC);
    pulse(8'h41);
    check("latency_early", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check("latency_start", {31'd0, tx_start}, 32'd1);
    check("single_data", {24'd0, tx_data}, {24'd0, 8'h41 + INC});
    check("single_echo_count", {16'd0, echo_count}, 32'd1);
    check("single_svn", {28'd0, svn_seg_0}, 32'h1);
    check("single_wait_ack", {31'd0, states_leds[1]}, 32'd1);
    wait_idle("single_settle");

    // Burst with overflow
    hold_busy = 1'b1;
    n0 = n_start;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back(8'(i) + INC);
      pulse(8'(i));
    end
    check("burst_overflow", {31'd0, overflow}, 32'd1);
    check("burst_flags", {29'd0, states_leds[5:3]}, 32'b110);
    check("burst_busy_led", {31'd0, states_leds[6]}, 32'd1);
    check("burst_svn", {28'd0, svn_seg_0}, 32'h9);
    check("burst_no_pop", {16'd0, echo_count}, 32'd1);
    hold_busy = 1'b0;
    wait_idle("burst_settle");
    check("burst_starts", n_start - n0, 32'd8);
    check("burst_echo_count", {16'd0, echo_count}, 32'd9);
    check("burst_empty_led", {31'd0, states_leds[3]}, 32'd1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("overflow_cleared", {31'd0, overflow}, 32'd0);

    // Push and pop together on a full FIFO
    hold_busy = 1'b1;
    n0 = n_start;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h10 + 8'(i) + INC);
      pulse(8'h10 + 8'(i));
    end
    check("pp_full_before", {31'd0, states_leds[4]}, 32'd1);
    @(negedge clk);
    hold_busy = 1'b0;
    rx_ready = 1'b1;
    rx_data = 8'h18;
    exp_q.push_back(8'h18 + INC);
    @(negedge clk);
    rx_ready = 1'b0;
    check("pp_popped", {31'd0, tx_start}, 32'd1);
    check("pp_still_full", {31'd0, states_leds[4]}, 32'd1);
    check("pp_no_overflow", {31'd0, overflow}, 32'd0);
    wait_idle("pp_settle");
    check("pp_starts", n_start - n0, 32'd9);
    check("pp_overflow_end", {31'd0, overflow}, 32'd0);

    // Ack timeout
    ack_en = 1'b0;
    exp_q.push_back(8'h20 + INC);
    pulse(8'h20);
    @(negedge clk);
    check("tmo_first_start", {31'd0, tx_start}, 32'd1);
    exp_q.push_back(8'h21 + INC);
    pulse(8'h21);
    repeat (12) @(negedge clk);
    check("tmo_last_wait_ack", {31'd0, states_leds[1]}, 32'd1);
    @(negedge clk);
    check("tmo_back_idle", {31'd0, states_leds[0]}, 32'd1);
    check("tmo_no_early_start", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check("tmo_next_start", {31'd0, tx_start}, 32'd1);
    wait_idle("tmo_settle");
    ack_en = 1'b1;

    // echo_count wrap
    @(negedge clk);
    force dut.echo_count = 16'hFFFF;
    #1;
    release dut.echo_count;
    exp_q.push_back(8'h7F + INC);
    pulse(8'h7F);
    @(negedge clk);
    check("wrap_start", {31'd0, tx_start}, 32'd1);
    check("wrap_echo_count", {16'd0, echo_count}, 32'd0);
    wait_idle("wrap_settle");

    // Async reset during WAIT_DONE, with a second byte still buffered
    exp_q.push_back(8'h55 + INC);
    pulse(8'h55);
    pulse(8'h56);
    k = 0;
    while (!states_leds[2] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ar_reach_wait_done", {31'd0, k < 100}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("ar_tx_start", {31'd0, tx_start}, 32'd0);
    check("ar_tx_data", {24'd0, tx_data}, 32'd0);
    check("ar_svn", {28'd0, svn_seg_0}, 32'd0);
    check("ar_leds", {22'd0, states_leds}, 32'd0);
    check("ar_echo_count", {16'd0, echo_count}, 32'd0);
    check("ar_overflow", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    n0 = n_start;
    repeat (30) @(negedge clk);
    check("ar_no_start", n_start - n0, 32'd0);
    check("ar_idle_leds", {22'd0, states_leds}, 32'h009);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

- Host-facing responder for the UART link: accepts received bytes (`rx_ready`/`rx_data` from the UART receiver), buffers them in a small FIFO and returns each one through the UART transmitter (`tx_start`/`tx_data`/`tx_busy`).
- It is the far-end counterpart of the UART test initiator: the initiator sends a byte and waits for a reply; this block produces that reply.
- Sits between the UART RX and TX cores on the DE10 board, with status on LEDs and one 7-segment digit.

## Interface
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, 2..64.
- `INCR`, default 1: 8-bit value added to each echoed byte when `UART_ECHO_INCR_EN` is defined.
- `ACK_TIMEOUT`, default 15: cycles to wait for `tx_busy` to rise after `tx_start`; range 1..255.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_ready`  in  1  one-cycle pulse; `rx_data` valid this cycle.
- `rx_data`  in  8  received byte.
- `tx_busy`  in  1  transmitter busy.
- `tx_data`  out  8  byte to transmit; registered.
- `tx_start`  out  1  one-cycle transmit request; registered.
- `svn_seg_0`  out  4  low nibble of the last received byte.
- `states_leds`  out  10  status; bit map given under Operation.
- `echo_count`  out  16  bytes handed to TX; wraps at 16'hFFFF to 0.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.

## Operation
- **Reset:** while `rst` is high, all outputs are 0, the FIFO is empty, the FSM is in IDLE and the timeout counter is 0.
- **FIFO write:** an `rx_ready` pulse with the FIFO not full writes `rx_data` at the clock edge that ends the pulse cycle. `svn_seg_0` <= `rx_data[3:0]` on every `rx_ready` pulse, including dropped bytes.
- **Full FIFO:** the byte is dropped and `overflow` <= 1. `overflow` is cleared only by `rst`.
- **Occupancy and pointers:** occupancy is held in a `log2(FIFO_DEPTH)+1`-bit count. Pointers wrap modulo `FIFO_DEPTH`.
- **Simultaneous push and pop:** both take effect and occupancy is unchanged. This also applies when the FIFO is full: the pop frees the entry, so the byte is accepted and not dropped.
- **FSM states:**
  - IDLE: if the FIFO is not empty and `tx_busy` is 0, pop the head, load `tx_data`, set `tx_start` <= 1, increment `echo_count`, and go to WAIT_ACK.
  - WAIT_ACK: `tx_start` <= 0.
    - If `tx_busy` is 1, go to WAIT_DONE.
    - Otherwise increment the timeout counter. When it reaches `ACK_TIMEOUT`, go to IDLE; the byte is considered sent.
  - WAIT_DONE: go to IDLE when `tx_busy` is 0.
  - Any illegal encoding goes to IDLE.
- **Echoed byte:** `tx_data` is the popped byte. With `UART_ECHO_INCR_EN` defined it is (byte + `INCR`) mod 256.
- **`states_leds` bit map:** all bits are live (not sticky).
  - [0] IDLE, [1] WAIT_ACK, [2] WAIT_DONE.
  - [3] FIFO empty, [4] FIFO full, [5] `overflow`.
  - [6] `tx_busy`.
  - [9:7] = 0.

## Timing
- **Latency:** an `rx_ready` pulse in cycle N into an empty FIFO, with the FSM in IDLE and `tx_busy` low, gives `tx_start` high in cycle N+2, with `tx_data` valid in the same cycle.
- **`tx_start` width:** exactly one cycle per byte. It is never asserted while the FSM is outside IDLE→WAIT_ACK.
- **Back-to-back bytes:** the earliest next `tx_start` comes 2 cycles after `tx_busy` falls (WAIT_DONE→IDLE, then IDLE→WAIT_ACK).
- **`tx_data`:** holds its value until the next pop.
- **Status outputs:** `echo_count` and the `states_leds` flags change on the same edge as the event that causes them.
- **Reset mid-operation:** an asynchronous `rst` mid-transfer discards the FIFO contents and the in-flight state. Outputs return to their reset values immediately, without waiting for a clock edge.

## Configuration
- **`UART_ECHO_INCR_EN` defined:** echoed byte = received byte + `INCR` (mod 256), e.g. 'A' (8'h41) is returned as 'B' (8'h42) with `INCR`=1.
- **Not defined:** the byte is echoed unchanged, and `INCR` is ignored.

## Test plan
- **Single echo:** with `UART_ECHO_INCR_EN` defined and `INCR`=1, pulse `rx_ready` with 8'h41. A TX model raises `tx_busy` 1 cycle after `tx_start` and holds it 10 cycles. Required: `tx_start` is high 2 cycles after the pulse, `tx_data`=8'h42, `echo_count`=1, `svn_seg_0`=4'h1.
- **Burst and overflow:** with `FIFO_DEPTH`=8, hold `tx_busy`=1 and pulse `rx_ready` 10 times with bytes 0..9. Required: bytes 8 and 9 are dropped and `overflow`=1. After releasing `tx_busy`, exactly 8 `tx_start` pulses occur with data 1..8 (incr build) in order; `states_leds[3]` returns to 1.
- **Simultaneous push/pop with full FIFO:** apply `rx_ready` in the same cycle as the IDLE pop. Required: occupancy stays at 8, no drop, `overflow` stays 0.
- **Ack timeout:** the TX model never raises `tx_busy`. Required: the FSM returns to IDLE after 15 cycles in WAIT_ACK, and the next byte's `tx_start` follows.
- **Counter wrap:** preload `echo_count`=16'hFFFF via force, then echo one byte. Required: `echo_count`=0.
- **Async reset mid-transfer:** assert `rst` during WAIT_DONE, between clock edges. Required: all outputs are 0 before the next edge. After release, no `tx_start` occurs until a new `rx_ready`.
